axis_fifo: RTL and testbench
============================

// Module: axis_fifo
//
// PURPOSE
//   Parametrised single-clock stream FIFO with valid/ready handshakes on both sides.
//   Carries a TLAST-style end-of-packet flag with each word and reports fill level and
//   almost-full/almost-empty thresholds.
//   Optional packet (store-and-forward) mode releases data only once a whole packet is stored.
//   Sits between stream producers/consumers in the datapath; it replaces bare push/pop FIFOs
//   wherever back-pressure is needed.
//
// PARAMETERS
//   T_DATA_WIDTH  8  payload width in bits, >=1
//   DATA_DEPTH    16 number of entries; power of two, >=2
//   AF_THRESH     12 almost_full_o asserts when level_o >= AF_THRESH (1..DATA_DEPTH)
//   AE_THRESH     2  almost_empty_o asserts when level_o <= AE_THRESH (0..DATA_DEPTH-1)
//   PACKET_MODE   0  0 = word-level fall-through; 1 = store-and-forward per packet
//
// PORTS
//   clk            in   1                    clock, all state on rising edge
//   rst            in   1                    asynchronous reset, active-high
//   s_data_i       in   T_DATA_WIDTH         input payload
//   s_last_i       in   1                    input end-of-packet flag
//   s_valid_i      in   1                    input word valid
//   s_ready_o      out  1                    FIFO can accept a word
//   m_data_o       out  T_DATA_WIDTH         head-of-FIFO payload
//   m_last_o       out  1                    head-of-FIFO end-of-packet flag
//   m_valid_o      out  1                    head word presentable
//   m_ready_i      in   1                    consumer accepts head word
//   level_o        out  $clog2(DATA_DEPTH)+1 number of stored words, 0..DATA_DEPTH
//   pkt_cnt_o      out  $clog2(DATA_DEPTH)+1 number of complete packets stored (last flags held)
//   almost_full_o  out  1                    level_o >= AF_THRESH
//   almost_empty_o out  1                    level_o <= AE_THRESH
//
// BEHAVIOUR
//   - Pointers: rd/wr pointers of ADDRESS_WIDTH+1 bits, where ADDRESS_WIDTH = $clog2(DATA_DEPTH).
//     The extra MSB distinguishes full from empty; pointers wrap naturally modulo 2*DATA_DEPTH.
//   - Push = s_valid_i & s_ready_o.
//   - Pop = m_valid_o & m_ready_i.
//   - Words not pushed/popped under these conditions are ignored; no overflow or underflow is possible.
//   - s_ready_o = !full & !rst. It is combinational from state and does not depend on m_ready_i.
//     When full, a same-cycle pop does NOT admit a push.
//   - Storage: {s_last_i, s_data_i} is written at wr pointer on push. The memory array is not reset.
//   - m_data_o/m_last_o are read combinationally at the rd pointer (first-word fall-through).
//     Their value is don't-care while m_valid_o = 0.
//   - Latency: a word pushed at edge N can be presented with m_valid_o = 1 after edge N.
//     Empty FIFO gives no same-cycle bypass.
//   - m_valid_o:
//       PACKET_MODE = 0: !empty.
//       PACKET_MODE = 1: !empty & (pkt_cnt_o != 0 | full).
//       The "| full" term is the oversize-packet escape: a packet longer than DATA_DEPTH
//       streams out cut-through instead of deadlocking.
//   - m_valid_o, once high, stays high and m_data_o stays stable until pop. This holds in
//     both modes; in PACKET_MODE the escape path stays open until the last word pops.
//   - level_o = wr_ptr - rd_ptr, computed at full pointer width.
//       Push only: +1. Pop only: -1. Both: unchanged.
//   - pkt_cnt_o:
//       +1 on push with s_last_i = 1.
//       -1 on pop with m_last_o = 1.
//       Both in one cycle: unchanged.
//   - almost_full_o / almost_empty_o are combinational compares on level_o.
//   - Reset (rst = 1, asynchronous, any time incl. mid-packet):
//       pointers, level_o and pkt_cnt_o go to 0 immediately.
//       m_valid_o = 0, s_ready_o = 0, almost_full_o = 0, almost_empty_o = 1.
//       Partial packets are discarded.
//     After deassert, s_ready_o = 1 on the first cycle.
//
// TESTING
//   1. Reset, then push 0x01..0x10 (DEPTH = 16), m_ready_i = 0
//      -> level_o = 16, s_ready_o = 0, almost_full_o = 1 from 12th word on.
//      Then drain -> data 0x01..0x10 in order, almost_empty_o = 1 at level 2.
//   2. Full FIFO, s_valid_i = 1 and m_ready_i = 1 same cycle
//      -> one pop, no push, level_o = 15. Next cycle push accepted, level_o = 16.
//   3. Continuous s_valid_i = m_ready_i = 1 for 40 words
//      -> level_o steady at 1, order preserved across pointer wrap (>2*DEPTH words).
//   4. PACKET_MODE = 1: push 3-word packet with last on word 3
//      -> m_valid_o = 0 until cycle after word 3, pkt_cnt_o = 1, then 3 pops with m_last_o on the 3rd.
//   5. PACKET_MODE = 1: push 20-word packet
//      -> at level_o = 16, m_valid_o = 1 (escape), all 20 words delivered in order, pkt_cnt_o returns to 0.
//   6. Assert rst mid-packet with level_o = 5
//      -> same cycle level_o = 0, m_valid_o = 0, pkt_cnt_o = 0.
//      After release, a new packet passes cleanly.

Source files
------------

// File: rtl/axis_fifo.sv
// Single-clock valid/ready stream FIFO with end-of-packet flag, fill level and thresholds.
// PACKET_MODE=1 holds words back until a complete packet (or a full FIFO) is stored.
module axis_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int DATA_DEPTH   = 16,
  parameter int AF_THRESH    = 12,
  parameter int AE_THRESH    = 2,
  parameter int PACKET_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [T_DATA_WIDTH-1:0]       s_data_i,
  input  logic                          s_last_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [T_DATA_WIDTH-1:0]       m_data_o,
  output logic                          m_last_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(DATA_DEPTH):0]   level_o,
  output logic [$clog2(DATA_DEPTH):0]   pkt_cnt_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_L = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_L = AE_THRESH[AW:0];

  logic [T_DATA_WIDTH:0] mem [DATA_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           pkt_cnt;
  logic                  esc;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  pkt_ok;
  logic [T_DATA_WIDTH:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign s_ready_o = ~full & ~rst;
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign m_data_o = head[T_DATA_WIDTH-1:0];
  assign m_last_o = head[T_DATA_WIDTH];

  // esc keeps an oversize packet flowing once it has filled the FIFO, until its last word leaves
  assign pkt_ok    = (PACKET_MODE == 0) || (pkt_cnt != '0) || full || esc;
  assign m_valid_o = ~empty & pkt_ok;

  assign level_o        = wr_ptr - rd_ptr;
  assign pkt_cnt_o      = pkt_cnt;
  assign almost_full_o  = (level_o >= AF_L);
  assign almost_empty_o = (level_o <= AE_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      esc     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      case ({push & s_last_i, pop & m_last_o})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
      esc <= (esc | full) & ~(pop & m_last_o);
    end
  end

  // Storage is data-only and carries no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_last_i, s_data_i};
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: one word-level and one packet-mode instance checked every cycle
// against a queue-based reference model.
module tb_axis_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data0, s_data1, m_data0, m_data1;
  logic       s_last0, s_last1, s_valid0, s_valid1, s_ready0, s_ready1;
  logic       m_last0, m_last1, m_valid0, m_valid1, m_ready0, m_ready1;
  logic [4:0] level0, level1, pkt0, pkt1;
  logic       af0, af1, ae0, ae1;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         esc1;
  bit         rst_m;
  bit         last_push1;

  always #5 clk = ~clk;

  axis_fifo #(.T_DATA_WIDTH(8), .DATA_DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .PACKET_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data0), .s_last_i(s_last0), .s_valid_i(s_valid0), .s_ready_o(s_ready0),
    .m_data_o(m_data0), .m_last_o(m_last0), .m_valid_o(m_valid0), .m_ready_i(m_ready0),
    .level_o(level0), .pkt_cnt_o(pkt0), .almost_full_o(af0), .almost_empty_o(ae0)
  );

  axis_fifo #(.T_DATA_WIDTH(8), .DATA_DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .PACKET_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data1), .s_last_i(s_last1), .s_valid_i(s_valid1), .s_ready_o(s_ready1),
    .m_data_o(m_data1), .m_last_o(m_last1), .m_valid_o(m_valid1), .m_ready_i(m_ready1),
    .level_o(level1), .pkt_cnt_o(pkt1), .almost_full_o(af1), .almost_empty_o(ae1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lasts(input int k);
    int n = 0;
    if (k == 0) begin
      foreach (q0[i]) if (q0[i][8]) n++;
    end else begin
      foreach (q1[i]) if (q1[i][8]) n++;
    end
    return n;
  endfunction

  // Packet mode presents the head only for a complete packet, a full FIFO, or an oversize packet already released
  function automatic bit exp_valid(input int k);
    if (k == 0) return q0.size() > 0;
    return (q1.size() > 0) && (lasts(1) > 0 || q1.size() == 16 || esc1);
  endfunction

  task automatic check_all();
    chk("lvl0",  {27'd0, level0}, q0.size());
    chk("rdy0",  {31'd0, s_ready0}, {31'd0, !rst_m && q0.size() < 16});
    chk("vld0",  {31'd0, m_valid0}, {31'd0, exp_valid(0)});
    chk("pkt0",  {27'd0, pkt0}, lasts(0));
    chk("af0",   {31'd0, af0}, {31'd0, q0.size() >= 12});
    chk("ae0",   {31'd0, ae0}, {31'd0, q0.size() <= 2});
    if (exp_valid(0)) chk("head0", {23'd0, m_last0, m_data0}, {23'd0, q0[0]});
    chk("lvl1",  {27'd0, level1}, q1.size());
    chk("rdy1",  {31'd0, s_ready1}, {31'd0, !rst_m && q1.size() < 16});
    chk("vld1",  {31'd0, m_valid1}, {31'd0, exp_valid(1)});
    chk("pkt1",  {27'd0, pkt1}, lasts(1));
    chk("af1",   {31'd0, af1}, {31'd0, q1.size() >= 12});
    chk("ae1",   {31'd0, ae1}, {31'd0, q1.size() <= 2});
    if (exp_valid(1)) chk("head1", {23'd0, m_last1, m_data1}, {23'd0, q1[0]});
  endtask

  task automatic step(input logic v0, input logic [7:0] d0, input logic l0, input logic r0,
                      input logic v1, input logic [7:0] d1, input logic l1, input logic r1);
    bit push0, pop0, push1, pop1, hl1;
    s_valid0 = v0; s_data0 = d0; s_last0 = l0; m_ready0 = r0;
    s_valid1 = v1; s_data1 = d1; s_last1 = l1; m_ready1 = r1;
    #1 check_all();
    push0 = v0 && !rst_m && q0.size() < 16;
    pop0  = r0 && exp_valid(0);
    push1 = v1 && !rst_m && q1.size() < 16;
    pop1  = r1 && exp_valid(1);
    hl1   = pop1 && q1[0][8];
    @(posedge clk);
    if (!rst_m) begin
      if (pop0)  void'(q0.pop_front());
      if (push0) q0.push_back({l0, d0});
      if (pop1)  void'(q1.pop_front());
      if (push1) q1.push_back({l1, d1});
      if (hl1) esc1 = 1'b0;
      if (q1.size() == 16) esc1 = 1'b1;
    end
    last_push1 = push1;
    @(negedge clk);
  endtask

  initial begin
    int pushed;
    rst = 1'b1; rst_m = 1'b1; esc1 = 1'b0;
    {s_valid0, s_last0, m_ready0, s_valid1, s_last1, m_ready1} = '0;
    s_data0 = '0; s_data1 = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8'h55, 0, 1, 1, 8'h66, 1, 1);
    rst = 1'b0; rst_m = 1'b0;

    // Fill the word-level FIFO with consumer stalled, then overfill attempt
    for (int i = 1; i <= 16; i++) step(1, i[7:0], i == 16, 0, 0, 0, 0, 0);
    chk("fill_level", {27'd0, level0}, 16);
    step(1, 8'hEE, 0, 0, 0, 0, 0, 0);
    // Full with both sides active: pop only, then the push lands next cycle
    step(1, 8'hAA, 0, 1, 0, 0, 0, 0);
    chk("pop_nopush_level", {27'd0, level0}, 15);
    step(1, 8'hAB, 1, 0, 0, 0, 0, 0);
    chk("refill_level", {27'd0, level0}, 16);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 0, 0, 0, 0);

    // Streaming through the pointer wrap
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1'($urandom), 1, 0, 0, 0, 0);
    chk("stream_level", {27'd0, level0}, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // Packet mode: short packet held back until its last word is stored
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h30 + 8'(i), i == 2, 1);
    chk("pkt_released", {31'd0, m_valid1}, 1);
    chk("pkt_count", {27'd0, pkt1}, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);

    // Packet mode: oversize packet escapes once the FIFO is full
    pushed = 0;
    for (int cyc = 0; cyc < 80 && (pushed < 20 || q1.size() > 0); cyc++) begin
      if (level1 == 5'd16) chk("escape_valid", {31'd0, m_valid1}, 1);
      step(0, 0, 0, 0, pushed < 20, 8'h40 + 8'(pushed), pushed == 19, cyc >= 20);
      if (last_push1) pushed++;
    end
    chk("oversize_pushed", pushed, 20);
    chk("oversize_pkt_cnt", {27'd0, pkt1}, 0);

    // Asynchronous reset in the middle of a packet
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'h70 + 8'(i), 0, 0);
    chk("pre_reset_level", {27'd0, level1}, 5);
    #2 rst = 1'b1; rst_m = 1'b1;
    q0.delete(); q1.delete(); esc1 = 1'b0;
    #1 check_all();
    @(negedge clk);
    rst = 1'b0; rst_m = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 8'h90 + 8'(i), i == 3, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("post_reset_empty", {27'd0, level1}, 0);

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
           1'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 24; i++) step(0, 0, 0, 1, 1, 8'hFF, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0, 0, 1);
    chk("final_empty0", {27'd0, level0}, 0);
    chk("final_empty1", {27'd0, level1}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
